// File: rtl/mvb_merge_rr.sv
// ============================================================================
// Module  : mvb_merge_rr
// Brief   : Round-robin merge of INPUTS MVB streams into one registered MVB
//           output, with optional burst locking (BURST_MAX words per grant).
//           Define MVB_MERGE_SRC_ID_EN to add the TX_SRC_ID output.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module mvb_merge_rr #(
  parameter int INPUTS     = 4,
  parameter int ITEMS      = 4,
  parameter int ITEM_WIDTH = 32,
  parameter int BURST_MAX  = 1
) (
  input  logic                                CLK,
  input  logic                                RESET,
  input  logic [INPUTS*ITEMS*ITEM_WIDTH-1:0]  RX_DATA,
  input  logic [INPUTS*ITEMS-1:0]             RX_VLD,
  input  logic [INPUTS-1:0]                   RX_SRC_RDY,
  output logic [INPUTS-1:0]                   RX_DST_RDY,
  output logic [ITEMS*ITEM_WIDTH-1:0]         TX_DATA,
  output logic [ITEMS-1:0]                    TX_VLD,
  output logic                                TX_SRC_RDY,
`ifdef MVB_MERGE_SRC_ID_EN
  output logic [$clog2(INPUTS)-1:0]           TX_SRC_ID,
`endif
  input  logic                                TX_DST_RDY
);

  localparam int c_ID_W   = $clog2(INPUTS);
  localparam int c_CNT_W  = $clog2(BURST_MAX + 1);
  localparam int c_WORD_W = ITEMS * ITEM_WIDTH;

  typedef enum logic [0:0] {S_ARB = 1'b0, S_BURST = 1'b1} state_t;

  state_t              r_state, w_state_nxt;
  logic [c_ID_W-1:0]   r_ptr, w_ptr_nxt;
  logic [c_ID_W-1:0]   r_lock, w_lock_nxt;
  logic [c_CNT_W-1:0]  r_cnt, w_cnt_nxt;

  logic                r_tx_src_rdy;
  logic [ITEMS-1:0]    r_tx_vld;
  logic [c_WORD_W-1:0] r_tx_data;

  logic                w_free, w_hold, w_gnt_vld, w_xfer;
  logic [c_ID_W-1:0]   w_gnt, w_start;
  logic [c_WORD_W-1:0] w_rx_data;
  logic [ITEMS-1:0]    w_rx_vld;

  function automatic logic [c_ID_W-1:0] f_wrap_inc(input logic [c_ID_W-1:0] i);
    if (int'(i) == INPUTS - 1) return '0;
    return i + 1'b1;
  endfunction

  assign w_free = !r_tx_src_rdy || TX_DST_RDY;
  assign w_xfer = !RESET && w_free && w_gnt_vld;

  // A locked burst keeps its owner while it requests; otherwise search
  // round-robin, starting after the lock so a dropped owner costs no bubble.
  always_comb begin
    int v_idx;
    w_gnt_vld = 1'b0;
    w_gnt     = '0;
    v_idx     = 0;
    w_start   = (r_state == S_BURST) ? f_wrap_inc(r_lock) : r_ptr;
    w_hold    = (r_state == S_BURST) && RX_SRC_RDY[r_lock];
    if (w_hold) begin
      w_gnt_vld = 1'b1;
      w_gnt     = r_lock;
    end else begin
      for (int k = INPUTS - 1; k >= 0; k--) begin
        v_idx = int'(w_start) + k;
        if (v_idx >= INPUTS) v_idx = v_idx - INPUTS;
        if (RX_SRC_RDY[v_idx]) begin
          w_gnt_vld = 1'b1;
          w_gnt     = c_ID_W'(v_idx);
        end
      end
    end
  end

  always_comb begin
    RX_DST_RDY = '0;
    if (w_xfer) RX_DST_RDY[w_gnt] = 1'b1;
  end

  assign w_rx_data = RX_DATA[w_gnt*c_WORD_W +: c_WORD_W];
  assign w_rx_vld  = RX_VLD[w_gnt*ITEMS +: ITEMS];

  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_state <= S_ARB;
      r_ptr   <= '0;
      r_lock  <= '0;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_ptr   <= w_ptr_nxt;
      r_lock  <= w_lock_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_ptr_nxt   = r_ptr;
    w_lock_nxt  = r_lock;
    w_cnt_nxt   = r_cnt;
    if (w_xfer) begin
      if (w_hold) begin
        if (int'(r_cnt) + 1 == BURST_MAX) begin
          w_ptr_nxt   = f_wrap_inc(r_lock);
          w_cnt_nxt   = '0;
          w_state_nxt = S_ARB;
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end else if (BURST_MAX == 1) begin
        w_ptr_nxt   = f_wrap_inc(w_gnt);
        w_state_nxt = S_ARB;
      end else begin
        w_lock_nxt  = w_gnt;
        w_cnt_nxt   = c_CNT_W'(1);
        w_state_nxt = S_BURST;
      end
    end
  end

  // Words with no valid item are consumed but never reach the output.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_tx_src_rdy <= 1'b0;
      r_tx_vld     <= '0;
    end else if (w_xfer && |w_rx_vld) begin
      r_tx_src_rdy <= 1'b1;
      r_tx_vld     <= w_rx_vld;
      r_tx_data    <= w_rx_data;
    end else if (TX_DST_RDY) begin
      r_tx_src_rdy <= 1'b0;
    end
  end

`ifdef MVB_MERGE_SRC_ID_EN
  logic [c_ID_W-1:0] r_tx_id;

  always_ff @(posedge CLK) begin
    if (RESET) r_tx_id <= '0;
    else if (w_xfer && |w_rx_vld) r_tx_id <= w_gnt;
  end

  assign TX_SRC_ID = r_tx_id;
`endif

  assign TX_SRC_RDY = r_tx_src_rdy;
  assign TX_VLD     = r_tx_vld;
  assign TX_DATA    = r_tx_data;

endmodule

`default_nettype wire

// File: tb/tb_mvb_merge_rr.sv
// ============================================================================
// Module  : tb_mvb_merge_rr
// Brief   : Two merger instances (BURST_MAX 1 and 3) on shared stimulus,
//           checked every cycle against a queue-free round-robin model.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mvb_merge_rr;

  localparam int N  = 4;
  localparam int IT = 4;
  localparam int IW = 32;
  localparam int WW = IT * IW;

  logic                clk;
  logic                rst;
  logic [N*WW-1:0]     rx_data;
  logic [N*IT-1:0]     rx_vld;
  logic [N-1:0]        rx_src_rdy;
  logic                tx_dst_rdy;

  logic [N-1:0]        dst_rdy_o [2];
  logic [WW-1:0]       tx_data_o [2];
  logic [IT-1:0]       tx_vld_o  [2];
  logic                tx_srdy_o [2];
`ifdef MVB_MERGE_SRC_ID_EN
  logic [1:0]          tx_id_o   [2];
`endif

  int n_vec = 0;
  int n_err = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  mvb_merge_rr #(.INPUTS(N), .ITEMS(IT), .ITEM_WIDTH(IW), .BURST_MAX(1)) u_dut1 (
    .CLK(clk), .RESET(rst), .RX_DATA(rx_data), .RX_VLD(rx_vld),
    .RX_SRC_RDY(rx_src_rdy), .RX_DST_RDY(dst_rdy_o[0]),
    .TX_DATA(tx_data_o[0]), .TX_VLD(tx_vld_o[0]), .TX_SRC_RDY(tx_srdy_o[0]),
`ifdef MVB_MERGE_SRC_ID_EN
    .TX_SRC_ID(tx_id_o[0]),
`endif
    .TX_DST_RDY(tx_dst_rdy)
  );

  mvb_merge_rr #(.INPUTS(N), .ITEMS(IT), .ITEM_WIDTH(IW), .BURST_MAX(3)) u_dut3 (
    .CLK(clk), .RESET(rst), .RX_DATA(rx_data), .RX_VLD(rx_vld),
    .RX_SRC_RDY(rx_src_rdy), .RX_DST_RDY(dst_rdy_o[1]),
    .TX_DATA(tx_data_o[1]), .TX_VLD(tx_vld_o[1]), .TX_SRC_RDY(tx_srdy_o[1]),
`ifdef MVB_MERGE_SRC_ID_EN
    .TX_SRC_ID(tx_id_o[1]),
`endif
    .TX_DST_RDY(tx_dst_rdy)
  );

  // Model: m_lock = burst owner (-1 when none), m_cnt = words it has used.
  int            c_bm [2] = '{1, 3};
  int            m_ptr  [2];
  int            m_lock [2];
  int            m_cnt  [2];
  bit            m_srdy [2];
  logic [WW-1:0] m_data [2];
  logic [IT-1:0] m_vld  [2];
  int            m_id   [2];

  function automatic void model_reset();
    for (int b = 0; b < 2; b++) begin
      m_ptr[b] = 0; m_lock[b] = -1; m_cnt[b] = 0;
      m_srdy[b] = 0; m_data[b] = '0; m_vld[b] = '0; m_id[b] = 0;
    end
  endfunction

  function automatic int model_grant(int b);
    int start;
    if (rst) return -1;
    if (m_srdy[b] && !tx_dst_rdy) return -1;
    if (m_lock[b] >= 0 && rx_src_rdy[m_lock[b]]) return m_lock[b];
    start = (m_lock[b] >= 0) ? (m_lock[b] + 1) % N : m_ptr[b];
    for (int k = 0; k < N; k++)
      if (rx_src_rdy[(start + k) % N]) return (start + k) % N;
    return -1;
  endfunction

  task automatic check(input string name, input int b, input logic [WW-1:0] act,
                       input logic [WW-1:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s dut%0d @%0t: got %h expected %h", name, b, $time, act, exp);
    end
  endtask

  task automatic check_model();
    for (int b = 0; b < 2; b++) begin
      int g;
      logic [WW-1:0] mask;
      g = model_grant(b);
      check("rx_dst_rdy", b, WW'(dst_rdy_o[b]), (g >= 0) ? WW'(1) << g : '0);
      check("tx_src_rdy", b, WW'(tx_srdy_o[b]), WW'(m_srdy[b]));
      if (m_srdy[b]) begin
        for (int j = 0; j < IT; j++) mask[j*IW +: IW] = {IW{m_vld[b][j]}};
        check("tx_vld", b, WW'(tx_vld_o[b]), WW'(m_vld[b]));
        check("tx_data", b, tx_data_o[b] & mask, m_data[b] & mask);
      end
`ifdef MVB_MERGE_SRC_ID_EN
      check("tx_src_id", b, WW'(tx_id_o[b]), WW'(m_id[b]));
`endif
    end
  endtask

  task automatic update_model();
    if (rst) begin
      model_reset();
      return;
    end
    for (int b = 0; b < 2; b++) begin
      int g;
      logic [IT-1:0] v;
      g = model_grant(b);
      if (g >= 0) begin
        if (m_lock[b] == g) begin
          m_cnt[b]++;
          if (m_cnt[b] == c_bm[b]) begin
            m_ptr[b] = (g + 1) % N; m_lock[b] = -1; m_cnt[b] = 0;
          end
        end else if (c_bm[b] == 1) begin
          m_ptr[b] = (g + 1) % N;
        end else begin
          m_lock[b] = g; m_cnt[b] = 1;
        end
        v = rx_vld[g*IT +: IT];
        if (|v) begin
          m_srdy[b] = 1; m_vld[b] = v; m_data[b] = rx_data[g*WW +: WW]; m_id[b] = g;
        end else if (tx_dst_rdy) m_srdy[b] = 0;
      end else if (tx_dst_rdy) m_srdy[b] = 0;
    end
  endtask

  // Called at the falling edge with inputs already driven and settled.
  task automatic run_cycle();
    check_model();
    @(posedge clk);
    update_model();
    @(negedge clk);
  endtask

  // Directed words carry a tag: item j of input i = A000_0i0j.
  task automatic drive(input logic [N-1:0] rdy, input logic [N*IT-1:0] vld);
    for (int i = 0; i < N; i++)
      for (int j = 0; j < IT; j++)
        rx_data[i*WW + j*IW +: IW] = 32'hA000_0000 | (i << 8) | j;
    rx_vld     = vld;
    rx_src_rdy = rdy;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    drive(4'hF, '1);
    tx_dst_rdy = 1'b1;
    #1;
    check("reset_dst_rdy", 0, WW'(dst_rdy_o[0]), '0);
    run_cycle();
    rst = 1'b0;
  endtask

  logic [3:0] lit_a1 [6] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001, 4'b0010};
  logic [3:0] lit_a3 [6] = '{4'b0001, 4'b0001, 4'b0001, 4'b0010, 4'b0010, 4'b0010};
  logic [3:0] lit_b3 [7] = '{4'b0010, 4'b0010, 4'b0010, 4'b0100, 4'b0100, 4'b0100, 4'b0010};
  logic [3:0] rdy_c  [5] = '{4'b0010, 4'b1000, 4'b1111, 4'b1111, 4'b1111};
  logic [3:0] lit_c3 [5] = '{4'b0010, 4'b1000, 4'b1000, 4'b1000, 4'b0001};

  initial begin
    model_reset();
    rst = 1'b1;
    tx_dst_rdy = 1'b1;
    drive(4'hF, '1);
    @(posedge clk);
    @(negedge clk);

    // Reset state, then all inputs ready with a free output.
    do_reset();
    check("reset_tx_src_rdy", 1, WW'(tx_srdy_o[1]), '0);
    check("reset_tx_vld", 0, WW'(tx_vld_o[0]), '0);
    for (int k = 0; k < 6; k++) begin
      drive(4'hF, '1);
      #1;
      check("a_order_bm1", 0, WW'(dst_rdy_o[0]), WW'(lit_a1[k]));
      check("a_order_bm3", 1, WW'(dst_rdy_o[1]), WW'(lit_a3[k]));
      check("a_tx_src_rdy", 0, WW'(tx_srdy_o[0]), (k == 0) ? '0 : WW'(1));
      if (k > 0)
        check("a_tx_item0", 0, WW'(tx_data_o[0][IW-1:0]),
              WW'(32'hA000_0000 | (((k - 1) % 4) << 8)));
      run_cycle();
    end

    // Only inputs 1 and 2 request: bursts of three alternate.
    do_reset();
    for (int k = 0; k < 7; k++) begin
      drive(4'b0110, '1);
      #1;
      check("b_burst_order", 1, WW'(dst_rdy_o[1]), WW'(lit_b3[k]));
      run_cycle();
    end

    // Burst owner drops after one word; input 3 takes over without a bubble.
    do_reset();
    for (int k = 0; k < 5; k++) begin
      drive(rdy_c[k], '1);
      #1;
      check("c_handover", 1, WW'(dst_rdy_o[1]), WW'(lit_c3[k]));
      run_cycle();
    end

    // Output back-pressure for five cycles holds word 0 and the pointer.
    do_reset();
    drive(4'hF, '1);
    #1;
    run_cycle();
    tx_dst_rdy = 1'b0;
    for (int k = 0; k < 5; k++) begin
      #1;
      check("d_stall_dst_rdy", 0, WW'(dst_rdy_o[0]), '0);
      check("d_stall_item0", 0, WW'(tx_data_o[0][IW-1:0]), WW'(32'hA000_0000));
      run_cycle();
    end
    tx_dst_rdy = 1'b1;
    #1;
    check("d_release", 0, WW'(dst_rdy_o[0]), WW'(4'b0010));
    run_cycle();

    // Input 2 sends an all-invalid word: consumed, nothing emitted.
    do_reset();
    drive(4'b0100, 16'h00FF);
    #1;
    check("e_empty_accept", 0, WW'(dst_rdy_o[0]), WW'(4'b0100));
    run_cycle();
    drive(4'b0000, '1);
    #1;
    check("e_no_tx", 0, WW'(tx_srdy_o[0]), '0);
    run_cycle();

    // Randomised traffic with occasional resets and empty words.
    for (int c = 0; c < 4000; c++) begin
      rst = ($urandom_range(0, 249) == 0);
      for (int w = 0; w < N * WW / 32; w++) rx_data[w*32 +: 32] = $urandom;
      for (int i = 0; i < N; i++)
        rx_vld[i*IT +: IT] = ($urandom_range(0, 5) == 0) ? '0 : IT'($urandom);
      rx_src_rdy = N'($urandom) & N'($urandom | $urandom);
      tx_dst_rdy = ($urandom_range(0, 3) != 0);
      #1;
      run_cycle();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire
